// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer for a req/ready instruction memory with one outstanding request.
// It holds the returned word while IF/ID is stalled, redirects on branch, and drops fetches a branch has made stale.
module fetch_controller #(
    parameter int LEN_ADDRESS     = 32,
    parameter int LEN_INSTRUCTION = 32,
    parameter int TIMEOUT_CYCLES  = 64,
    parameter int COUNT_WIDTH     = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       stall_in,
    input  logic                       is_branch,
    input  logic [LEN_ADDRESS-1:0]     branch_address,
    output logic                       mem_req,
    output logic [LEN_ADDRESS-1:0]     mem_addr,
    input  logic                       mem_ready,
    input  logic [LEN_INSTRUCTION-1:0] mem_rdata,
    output logic                       if_valid,
    output logic [LEN_INSTRUCTION-1:0] if_instruction,
    output logic [LEN_ADDRESS-1:0]     if_pc,
    output logic                       fetch_error,
    output logic [1:0]                 dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FETCH   = 2'd1,
        S_HOLD    = 2'd2,
        S_DISCARD = 2'd3
    } state_t;

    localparam logic [COUNT_WIDTH-1:0] TIMEOUT_LIMIT = COUNT_WIDTH'(TIMEOUT_CYCLES);

    state_t                     r_state;
    logic [LEN_ADDRESS-1:0]     r_fetch_addr;
    logic [LEN_ADDRESS-1:0]     r_mem_addr;
    logic [LEN_INSTRUCTION-1:0] r_hold_buf;
    logic                       r_if_valid;
    logic [LEN_INSTRUCTION-1:0] r_if_instruction;
    logic [LEN_ADDRESS-1:0]     r_if_pc;
    logic                       r_fetch_error;
    logic [COUNT_WIDTH-1:0]     r_timeout_cnt;

    state_t                     w_state_nxt;
    logic [LEN_ADDRESS-1:0]     w_fetch_addr_nxt;
    logic [LEN_ADDRESS-1:0]     w_mem_addr_nxt;
    logic [LEN_INSTRUCTION-1:0] w_hold_buf_nxt;
    logic                       w_if_valid_nxt;
    logic [LEN_INSTRUCTION-1:0] w_if_instruction_nxt;
    logic [LEN_ADDRESS-1:0]     w_if_pc_nxt;
    logic [COUNT_WIDTH-1:0]     w_timeout_cnt_nxt;
    logic [LEN_ADDRESS-1:0]     w_addr_plus4;
    logic                       w_mem_req;
    logic                       w_complete;
    logic                       w_waiting;

    // State register and registered datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= S_IDLE;
            r_fetch_addr     <= '0;
            r_mem_addr       <= '0;
            r_hold_buf       <= '0;
            r_if_valid       <= 1'b0;
            r_if_instruction <= '0;
            r_if_pc          <= '0;
            r_fetch_error    <= 1'b0;
            r_timeout_cnt    <= '0;
        end else begin
            r_state          <= w_state_nxt;
            r_fetch_addr     <= w_fetch_addr_nxt;
            r_mem_addr       <= w_mem_addr_nxt;
            r_hold_buf       <= w_hold_buf_nxt;
            r_if_valid       <= w_if_valid_nxt;
            r_if_instruction <= w_if_instruction_nxt;
            r_if_pc          <= w_if_pc_nxt;
            r_timeout_cnt    <= w_timeout_cnt_nxt;
            r_fetch_error    <= r_fetch_error | (w_timeout_cnt_nxt == TIMEOUT_LIMIT);
        end
    end

    assign w_addr_plus4 = r_fetch_addr + LEN_ADDRESS'(4);
    assign w_complete   = w_mem_req & mem_ready;
    assign w_waiting    = w_mem_req & ~mem_ready;

    // Next-state and next-datapath decode; is_branch outranks every other input.
    always_comb begin
        w_state_nxt          = r_state;
        w_fetch_addr_nxt     = r_fetch_addr;
        w_mem_addr_nxt       = r_mem_addr;
        w_hold_buf_nxt       = r_hold_buf;
        w_if_valid_nxt       = r_if_valid;
        w_if_instruction_nxt = r_if_instruction;
        w_if_pc_nxt          = r_if_pc;
        unique case (r_state)
            S_IDLE: begin
                w_state_nxt = S_FETCH;
                if (is_branch) begin
                    w_fetch_addr_nxt = branch_address;
                    w_mem_addr_nxt   = branch_address;
                end else begin
                    w_mem_addr_nxt   = r_fetch_addr;
                end
            end
            S_FETCH: begin
                if (is_branch) begin
                    w_fetch_addr_nxt = branch_address;
                    if (mem_ready) w_mem_addr_nxt = branch_address;
                    else           w_state_nxt    = S_DISCARD;
                end else if (mem_ready && !stall_in) begin
                    w_if_valid_nxt       = 1'b1;
                    w_if_instruction_nxt = mem_rdata;
                    w_if_pc_nxt          = w_addr_plus4;
                    w_fetch_addr_nxt     = w_addr_plus4;
                    w_mem_addr_nxt       = w_addr_plus4;
                end else if (mem_ready) begin
                    w_hold_buf_nxt = mem_rdata;
                    w_state_nxt    = S_HOLD;
                end else if (!stall_in) begin
                    w_if_valid_nxt = 1'b0;
                end
            end
            S_HOLD: begin
                if (is_branch) begin
                    w_fetch_addr_nxt = branch_address;
                    w_mem_addr_nxt   = branch_address;
                    w_state_nxt      = S_FETCH;
                end else if (!stall_in) begin
                    w_if_valid_nxt       = 1'b1;
                    w_if_instruction_nxt = r_hold_buf;
                    w_if_pc_nxt          = w_addr_plus4;
                    w_fetch_addr_nxt     = w_addr_plus4;
                    w_mem_addr_nxt       = w_addr_plus4;
                    w_state_nxt          = S_FETCH;
                end
            end
            S_DISCARD: begin
                if (is_branch) w_fetch_addr_nxt = branch_address;
                if (!stall_in) w_if_valid_nxt = 1'b0;
                if (mem_ready) begin
                    w_state_nxt    = S_FETCH;
                    w_mem_addr_nxt = is_branch ? branch_address : r_fetch_addr;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (is_branch) w_if_valid_nxt = 1'b0;

        // Wait counter saturates at the limit; the error flag is sticky.
        w_timeout_cnt_nxt = r_timeout_cnt;
        if (r_state == S_IDLE || w_complete) w_timeout_cnt_nxt = '0;
        else if (w_waiting && r_timeout_cnt != TIMEOUT_LIMIT)
            w_timeout_cnt_nxt = r_timeout_cnt + 1'b1;
    end

    // Output decode.
    always_comb begin
        w_mem_req = (r_state == S_FETCH) || (r_state == S_DISCARD);
    end

    assign mem_req        = w_mem_req;
    assign mem_addr       = r_mem_addr;
    assign if_valid       = r_if_valid;
    assign if_instruction = r_if_instruction;
    assign if_pc          = r_if_pc;
    assign fetch_error    = r_fetch_error;
    assign dbg_state      = r_state;

endmodule
